soc_run_ctrl: RTL and testbench

//  Parametrised reset/run controller for the SOPC: replaces fixed bench-delay reset release and hard stop time.

---
 rtl/soc_run_ctrl_pkg.sv | 17 +
 rtl/soc_run_ctrl_if.sv | 26 ++
 rtl/soc_run_ctrl_rst_sync.sv | 20 ++
 rtl/soc_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_soc_run_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/soc_run_ctrl_pkg.sv
// Shared encodings for the SOPC reset/run controller: FSM states and reset active levels.
package soc_run_ctrl_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

endpackage

// File: rtl/soc_run_ctrl_if.sv
// Control/status bundle between the run controller and the CPU/bench side.
interface soc_run_ctrl_if #(
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH   = 32
);
    logic                   restart;
    logic                   halt_req;
    logic                   pc_valid;
    logic [PC_WIDTH-1:0]    pc_in;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   running;
    logic                   done;
    logic                   timeout;
    logic [CNT_WIDTH-1:0]   cycle_count;

    modport master (
        output restart, halt_req, pc_valid, pc_in,
        input  dom_rst_n, running, done, timeout, cycle_count
    );

    modport slave (
        input  restart, halt_req, pc_valid, pc_in,
        output dom_rst_n, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/soc_run_ctrl_rst_sync.sv
// Two-flop reset synchroniser: asynchronous assertion, release aligned to clk.
module soc_run_ctrl_rst_sync
    import soc_run_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= RST_ENABLE;
            rst_sync_n <= RST_ENABLE;
        end else begin
            meta       <= RST_DISABLE;
            rst_sync_n <= meta;
        end
    end
endmodule

// File: rtl/soc_run_ctrl.sv
// Reset/run controller: staggered domain release, then PC self-loop / halt / budget run monitor.
module soc_run_ctrl
    import soc_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned RST_HOLD    = 10,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned TIMEOUT     = 800,
    parameter int unsigned HALT_REPEAT = 8,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic           CLOCK_50,
    input  logic           rst,
    soc_run_ctrl_if.slave  bus
);
    localparam int unsigned REL_LAST = (NUM_DOMAINS - 1) * STAGGER;
    localparam int unsigned HOLD_W   = $clog2(RST_HOLD + 1);
    localparam int unsigned REL_W    = $clog2(REL_LAST + 2);
    localparam int unsigned REP_W    = $clog2(HALT_REPEAT + 1);

    logic rst_sync_n;

    soc_run_ctrl_rst_sync u_rst_sync (
        .clk        (CLOCK_50),
        .rst_n      (rst),
        .rst_sync_n (rst_sync_n)
    );

    run_state_e             state,     state_n;
    logic [HOLD_W-1:0]      hold_cnt,  hold_cnt_n;
    logic [REL_W-1:0]       rel_cnt,   rel_cnt_n;
    logic [NUM_DOMAINS-1:0] dom_q,     dom_n;
    logic [CNT_WIDTH-1:0]   cycle_q,   cycle_n;
    logic [PC_WIDTH-1:0]    last_pc,   last_pc_n;
    logic [REP_W-1:0]       rep_cnt,   rep_n;
    logic                   running_q, running_n;
    logic                   done_q,    done_n;
    logic                   timeout_q, timeout_n;
    logic                   same_pc_c;
    logic                   halt_hit_c;

    // Domains whose release offset k*STAGGER has been reached by the RELEASE counter.
    function automatic logic [NUM_DOMAINS-1:0] release_mask(input logic [REL_W-1:0] cnt);
        logic [NUM_DOMAINS-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (cnt >= REL_W'(k * STAGGER)) m = m | (NUM_DOMAINS'(1) << k);
        end
        return m;
    endfunction

    assign same_pc_c  = bus.pc_valid && (bus.pc_in == last_pc);
    assign halt_hit_c = same_pc_c && (rep_cnt >= REP_W'(HALT_REPEAT - 1));

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        rel_cnt_n  = rel_cnt;
        dom_n      = dom_q;
        cycle_n    = cycle_q;
        last_pc_n  = last_pc;
        rep_n      = rep_cnt;

        unique case (state)
            ST_HOLD: begin
                dom_n = '0;
                if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    state_n    = ST_RELEASE;
                    hold_cnt_n = '0;
                    rel_cnt_n  = '0;
                    dom_n      = release_mask('0);
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (rel_cnt == REL_W'(REL_LAST)) begin
                    state_n   = ST_RUN;
                    cycle_n   = '0;
                    last_pc_n = '0;
                    rep_n     = '0;
                end else begin
                    rel_cnt_n = rel_cnt + REL_W'(1);
                    dom_n     = release_mask(rel_cnt_n);
                end
            end
            ST_RUN: begin
                if (bus.pc_valid) begin
                    if (same_pc_c) begin
                        if (rep_cnt != REP_W'(HALT_REPEAT)) rep_n = rep_cnt + REP_W'(1);
                    end else begin
                        rep_n     = REP_W'(1);
                        last_pc_n = bus.pc_in;
                    end
                end
                // Halt outranks the budget when both land on the same cycle.
                if (bus.halt_req || halt_hit_c) begin
                    state_n = ST_DONE;
                end else if (cycle_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    state_n = ST_TIMEOUT;
                end else if (cycle_q != '1) begin
                    cycle_n = cycle_q + CNT_WIDTH'(1);
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (bus.restart) begin
                    state_n    = ST_HOLD;
                    hold_cnt_n = '0;
                    dom_n      = '0;
                    cycle_n    = '0;
                    last_pc_n  = '0;
                    rep_n      = '0;
                end
            end
            default: begin
                state_n = ST_HOLD;
                dom_n   = '0;
            end
        endcase

        running_n = (state_n == ST_RUN);
        done_n    = (state_n == ST_DONE);
        timeout_n = (state_n == ST_TIMEOUT);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            rel_cnt   <= '0;
            dom_q     <= '0;
            cycle_q   <= '0;
            last_pc   <= '0;
            rep_cnt   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            rel_cnt   <= rel_cnt_n;
            dom_q     <= dom_n;
            cycle_q   <= cycle_n;
            last_pc   <= last_pc_n;
            rep_cnt   <= rep_n;
            running_q <= running_n;
            done_q    <= done_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.dom_rst_n   = dom_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// Directed bench for soc_run_ctrl: reset sequencing, halt detection, timeout, restart, async reset.
module tb_soc_run_ctrl;
    logic CLOCK_50;
    logic rst;
    int   n_vec;
    int   n_miss;

    soc_run_ctrl_if #(.NUM_DOMAINS(2), .PC_WIDTH(32), .CNT_WIDTH(32)) bus ();

    soc_run_ctrl #(
        .NUM_DOMAINS (2),
        .RST_HOLD    (10),
        .STAGGER     (4),
        .TIMEOUT     (800),
        .HALT_REPEAT (8),
        .PC_WIDTH    (32),
        .CNT_WIDTH   (32)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!bus.running && n < 100) begin
            tick(1);
            n++;
        end
        check_eq(tag, 64'(bus.running), 64'd1);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
    endtask

    // Alternate two PCs each cycle so the self-loop detector never fires.
    task automatic run_alternating(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pc_valid = 1'b1;
            bus.pc_in    = i[0] ? 32'h44 : 32'h40;
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b0;
        bus.restart  = 1'b0;
        bus.halt_req = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 32'h40;

        // T1: reset state and staggered release timing
        tick(5);
        check_eq("rst_dom",     64'(bus.dom_rst_n),   64'h0);
        check_eq("rst_running", 64'(bus.running),     64'h0);
        check_eq("rst_done",    64'(bus.done),        64'h0);
        check_eq("rst_timeout", 64'(bus.timeout),     64'h0);
        check_eq("rst_count",   64'(bus.cycle_count), 64'h0);
        rst = 1'b1;
        tick(11);
        check_eq("t1_dom_e11",  64'(bus.dom_rst_n), 64'h0);
        tick(1);
        check_eq("t1_dom_e12",  64'(bus.dom_rst_n), 64'h1);
        tick(3);
        check_eq("t1_dom_e15",  64'(bus.dom_rst_n), 64'h1);
        tick(1);
        check_eq("t1_dom_e16",  64'(bus.dom_rst_n), 64'h3);
        check_eq("t1_run_e16",  64'(bus.running),   64'h0);
        tick(1);
        check_eq("t1_run_e17",  64'(bus.running),   64'h1);
        check_eq("t1_cnt_e17",  64'(bus.cycle_count), 64'h0);

        // T2: constant PC from RUN cycle 0; restart in RUN must be ignored
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        tick(6);
        check_eq("t2_run_c7",   64'(bus.running),     64'h1);
        check_eq("t2_done_c7",  64'(bus.done),        64'h0);
        check_eq("t2_cnt_c7",   64'(bus.cycle_count), 64'd7);
        tick(1);
        check_eq("t2_done",     64'(bus.done),        64'h1);
        check_eq("t2_running",  64'(bus.running),     64'h0);
        check_eq("t2_cnt",      64'(bus.cycle_count), 64'd7);
        tick(3);
        check_eq("t2_cnt_hold", 64'(bus.cycle_count), 64'd7);
        check_eq("t2_done_hold",64'(bus.done),        64'h1);
        check_eq("t2_dom_hold", 64'(bus.dom_rst_n),   64'h3);
        pulse_restart();
        check_eq("t2_rs_dom",   64'(bus.dom_rst_n),   64'h0);
        check_eq("t2_rs_done",  64'(bus.done),        64'h0);
        check_eq("t2_rs_cnt",   64'(bus.cycle_count), 64'h0);

        // T3: alternating PC runs into the cycle budget
        wait_run("t3_wait_run");
        run_alternating(799);
        check_eq("t3_run_c799", 64'(bus.running),     64'h1);
        check_eq("t3_cnt_c799", 64'(bus.cycle_count), 64'd799);
        check_eq("t3_to_c799",  64'(bus.timeout),     64'h0);
        run_alternating(1);
        check_eq("t3_timeout",  64'(bus.timeout),     64'h1);
        check_eq("t3_done",     64'(bus.done),        64'h0);
        check_eq("t3_running",  64'(bus.running),     64'h0);
        check_eq("t3_cnt",      64'(bus.cycle_count), 64'd799);
        check_eq("t3_dom",      64'(bus.dom_rst_n),   64'h3);
        pulse_restart();
        check_eq("t3_rs_to",    64'(bus.timeout),     64'h0);

        // T4: constant PC, valid only on even RUN cycles -> 8th valid sample in cycle 14
        wait_run("t4_wait_run");
        for (int i = 0; i < 40 && !bus.done; i++) begin
            bus.pc_in    = 32'h40;
            bus.pc_valid = (i % 2 == 0);
            tick(1);
        end
        bus.pc_valid = 1'b1;
        check_eq("t4_done",     64'(bus.done),        64'h1);
        check_eq("t4_cnt",      64'(bus.cycle_count), 64'd14);
        pulse_restart();

        // T5: halt_req in the timeout cycle wins, then restart resequences
        wait_run("t5_wait_run");
        run_alternating(799);
        bus.halt_req = 1'b1;
        tick(1);
        bus.halt_req = 1'b0;
        check_eq("t5_done",     64'(bus.done),        64'h1);
        check_eq("t5_timeout",  64'(bus.timeout),     64'h0);
        check_eq("t5_cnt",      64'(bus.cycle_count), 64'd799);
        pulse_restart();
        check_eq("t5_rs_dom",   64'(bus.dom_rst_n),   64'h0);
        check_eq("t5_rs_done",  64'(bus.done),        64'h0);
        check_eq("t5_rs_cnt",   64'(bus.cycle_count), 64'h0);
        tick(9);
        check_eq("t5_hold_e9",  64'(bus.dom_rst_n),   64'h0);
        tick(1);
        check_eq("t5_rel_e10",  64'(bus.dom_rst_n),   64'h1);

        // T6: rst mid-RELEASE clears domains without waiting for a clock edge
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_dom",      64'(bus.dom_rst_n),   64'h0);
        check_eq("t6_running",  64'(bus.running),     64'h0);
        check_eq("t6_done",     64'(bus.done),        64'h0);
        check_eq("t6_timeout",  64'(bus.timeout),     64'h0);
        tick(3);
        rst = 1'b1;
        tick(11);
        check_eq("t6_re_e11",   64'(bus.dom_rst_n),   64'h0);
        tick(1);
        check_eq("t6_re_e12",   64'(bus.dom_rst_n),   64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
